d8m_pixel_capture: RTL and testbench

//  Captures the D8M camera parallel bus (FVAL/LVAL/DATA) on the phase-delayed pixel

---
 rtl/d8m_pkg.sv | 15 +
 rtl/d8m_edge_det.sv | 20 ++
 rtl/d8m_pixel_capture.sv | 143 ++++++++++++++
 tb/tb_d8m_pixel_capture.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/d8m_pkg.sv
// Shared widths and FSM state encoding for the D8M pixel capture path.
package d8m_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } stateT;

  localparam int D8M_DW      = 10;
  localparam int D8M_XW      = 12;
  localparam int D8M_YW      = 12;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/d8m_edge_det.sv
// Rise/fall pulse of a registered 1-bit level, compared against its previous sample.
module d8m_edge_det (
  input  logic clk,
  input  logic rstN,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic levelPrev;

  always_ff @(posedge clk) begin
    if (!rstN) levelPrev <= 1'b0;
    else       levelPrev <= level;
  end

  assign rise =  level & ~levelPrev;
  assign fall = ~level &  levelPrev;

endmodule

// File: rtl/d8m_pixel_capture.sv
// D8M parallel bus capture: whole-frame gating, X/Y tagging, geometry error and frame count.
//   state   | meaning
//   IDLE    | not capturing; waits for iSTART while the bus is between frames
//   ARMED   | waiting for the next frame-valid rising edge
//   CAPTURE | emitting accepted pixels of the current frame
module d8m_pixel_capture
  import d8m_pkg::*;
#(
  parameter int DW       = D8M_DW,
  parameter int XW       = D8M_XW,
  parameter int YW       = D8M_YW,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic                   iSTART,
  input  logic                   iFVAL,
  input  logic                   iLVAL,
  input  logic [DW-1:0]          iDATA,
  output logic                   oDVAL,
  output logic [DW-1:0]          oDATA,
  output logic [XW-1:0]          oX,
  output logic [YW-1:0]          oY,
  output logic                   oSOF,
  output logic                   oEOF,
  output logic [FRAME_CNT_W-1:0] oFRAME_CNT,
  output logic                   oERR
);

  localparam logic [1:0]    S_IDLE    = IDLE;
  localparam logic [1:0]    S_ARMED   = ARMED;
  localparam logic [1:0]    S_CAPTURE = CAPTURE;
  localparam logic [XW-1:0] XMAX      = XW'(H_ACTIVE);
  localparam logic [YW-1:0] YMAX      = YW'(V_ACTIVE);

  logic          rFVAL, rLVAL;
  logic [DW-1:0] rDATA;
  logic          rPrimed;
  logic          fvalRise, fvalFall, lvalRise, lvalFall;
  logic [1:0]    state;
  logic [XW-1:0] xCnt;
  logic [YW-1:0] yCnt;
  logic          lineHasPix;
  logic          pixIn, pixOk;

  // rPrimed keeps the reset value of rFVAL from looking like a frame gap.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      rFVAL   <= 1'b0;
      rLVAL   <= 1'b0;
      rDATA   <= '0;
      rPrimed <= 1'b0;
    end else begin
      rFVAL   <= iFVAL;
      rLVAL   <= iLVAL;
      rDATA   <= iDATA;
      rPrimed <= 1'b1;
    end
  end

  d8m_edge_det uFvalEdge (
    .clk   (iCLK),
    .rstN  (iRST_N),
    .level (rFVAL),
    .rise  (fvalRise),
    .fall  (fvalFall)
  );

  d8m_edge_det uLvalEdge (
    .clk   (iCLK),
    .rstN  (iRST_N),
    .level (rLVAL),
    .rise  (lvalRise),
    .fall  (lvalFall)
  );

  assign pixIn = (state == S_CAPTURE) && rFVAL && rLVAL;
  assign pixOk = pixIn && (xCnt < XMAX) && (yCnt < YMAX);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state      <= S_IDLE;
      xCnt       <= '0;
      yCnt       <= '0;
      lineHasPix <= 1'b0;
      oDVAL      <= 1'b0;
      oDATA      <= '0;
      oX         <= '0;
      oY         <= '0;
      oSOF       <= 1'b0;
      oEOF       <= 1'b0;
      oFRAME_CNT <= '0;
      oERR       <= 1'b0;
    end else begin
      oDVAL <= pixOk;
      oSOF  <= pixOk && (xCnt == '0) && (yCnt == '0);
      oEOF  <= 1'b0;

      if (lvalRise) lineHasPix <= 1'b0;

      if (pixOk) begin
        oDATA      <= rDATA;
        oX         <= xCnt;
        oY         <= yCnt;
        xCnt       <= xCnt + XW'(1);
        lineHasPix <= 1'b1;
      end

      if (pixIn && !pixOk) oERR <= 1'b1;

      case (state)
        S_IDLE: begin
          if (iSTART && !rFVAL && rPrimed) state <= S_ARMED;
        end
        S_ARMED: begin
          if (!iSTART) begin
            state <= S_IDLE;
          end else if (fvalRise) begin
            state      <= S_CAPTURE;
            xCnt       <= '0;
            yCnt       <= '0;
            lineHasPix <= 1'b0;
          end
        end
        S_CAPTURE: begin
          // Line end is folded in before frame end so a coincident edge still counts the line.
          if (lvalFall) begin
            xCnt <= '0;
            if (lineHasPix && (yCnt < YMAX)) yCnt <= yCnt + YW'(1);
          end
          if (fvalFall) begin
            oEOF       <= 1'b1;
            oFRAME_CNT <= oFRAME_CNT + FRAME_CNT_W'(1);
            state      <= iSTART ? S_ARMED : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d8m_pixel_capture.sv
// Self-checking bench for d8m_pixel_capture: cycle model plus directed frame scenarios.
module tb_d8m_pixel_capture;

  localparam int DW = 10;
  localparam int XW = 12;
  localparam int YW = 12;
  localparam int H  = 8;
  localparam int V  = 4;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iSTART = 1'b0;
  logic          iFVAL = 1'b0;
  logic          iLVAL = 1'b0;
  logic [DW-1:0] iDATA = '0;
  logic          oDVAL;
  logic [DW-1:0] oDATA;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic          oSOF;
  logic          oEOF;
  logic [15:0]   oFRAME_CNT;
  logic          oERR;

  d8m_pixel_capture #(
    .DW(DW), .XW(XW), .YW(YW), .H_ACTIVE(H), .V_ACTIVE(V)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iDATA(iDATA), .oDVAL(oDVAL), .oDATA(oDATA), .oX(oX), .oY(oY), .oSOF(oSOF),
    .oEOF(oEOF), .oFRAME_CNT(oFRAME_CNT), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      if (nFail <= 40) $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: what the outputs must be after each edge, from the bus history.
  int          mode = 0;   // 0 waiting for start, 1 armed, 2 capturing
  int          mx = 0, my = 0;
  bit          mHad = 0;
  bit          sFv1 = 0, sFv2 = 0, sLv1 = 0, sLv2 = 0, rstPrev = 0;
  logic [DW-1:0] sD1 = '0;
  bit          eDval = 0, eSof = 0, eEof = 0, eErr = 0;
  logic [DW-1:0] eData = '0;
  int          eX = 0, eY = 0;
  logic [15:0] eCnt = '0;

  always @(posedge iCLK) begin
    bit fv, lv, fvP, lvP;
    if (!iRST_N) begin
      mode = 0; mx = 0; my = 0; mHad = 0;
      eDval = 0; eSof = 0; eEof = 0; eErr = 0; eData = '0; eX = 0; eY = 0; eCnt = '0;
    end else begin
      fv  = sFv1;
      lv  = sLv1;
      fvP = rstPrev ? sFv2 : 1'b0;
      lvP = rstPrev ? sLv2 : 1'b0;
      eDval = 0; eSof = 0; eEof = 0;
      if (mode == 0) begin
        if (rstPrev && iSTART && !fv) mode = 1;
      end else if (mode == 1) begin
        if (!iSTART) mode = 0;
        else if (fv && !fvP) begin mode = 2; mx = 0; my = 0; mHad = 0; end
      end else begin
        if (fv && lv) begin
          if (mx < H && my < V) begin
            eDval = 1; eData = sD1; eX = mx; eY = my;
            eSof = (mx == 0 && my == 0);
            mx++; mHad = 1;
          end else eErr = 1;
        end
        if (!lv && lvP) begin
          if (mHad && my < V) my++;
          mx = 0; mHad = 0;
        end
        if (!fv && fvP) begin
          eEof = 1; eCnt = eCnt + 16'd1;
          mode = iSTART ? 1 : 0;
        end
      end
    end
    sFv2 = sFv1; sLv2 = sLv1;
    sFv1 = iRST_N ? iFVAL : 1'b0;
    sLv1 = iRST_N ? iLVAL : 1'b0;
    sD1  = iRST_N ? iDATA : '0;
    rstPrev = iRST_N;
    cyc++;
  end

  int dvalCnt = 0, sofCnt = 0, eofCnt = 0, firstCyc = 0, frameFirstDrive = 0;
  logic [XW-1:0] lastX = '0, firstX = '0;
  logic [YW-1:0] lastY = '0, firstY = '0;
  logic [DW-1:0] lastData = '0, sofData = '0;
  bit firstSof = 0;

  always @(negedge iCLK) begin
    if (cyc > 0) begin
      check("dval",  64'(oDVAL), 64'(eDval));
      check("data",  64'(oDATA), 64'(eData));
      check("x",     64'(oX), 64'(eX));
      check("y",     64'(oY), 64'(eY));
      check("sof",   64'(oSOF), 64'(eSof));
      check("eof",   64'(oEOF), 64'(eEof));
      check("fcnt",  64'(oFRAME_CNT), 64'(eCnt));
      check("err",   64'(oERR), 64'(eErr));
      if (oDVAL) begin
        if (dvalCnt == 0) begin firstX = oX; firstY = oY; firstSof = oSOF; firstCyc = cyc; end
        dvalCnt++; lastX = oX; lastY = oY; lastData = oDATA;
      end
      if (oSOF) begin sofCnt++; sofData = oDATA; end
      if (oEOF) eofCnt++;
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  task automatic clearCounters();
    dvalCnt = 0; sofCnt = 0; eofCnt = 0; firstCyc = 0; firstSof = 0;
  endtask

  // One frame of 'lines' lines; optional long line, start/stop line, coincident end, mid-frame reset.
  task automatic sendFrame(input int lines, input int ppl, input int longLine, input int longLen,
                           input int armLine, input int stopLine, input bit coinc,
                           input int rstLine, input int rstPix);
    iFVAL = 1'b1; iLVAL = 1'b0;
    tick(); tick();
    for (int ln = 0; ln < lines; ln++) begin
      int n;
      n = (ln == longLine) ? longLen : ppl;
      if (ln == armLine)  iSTART = 1'b1;
      if (ln == stopLine) iSTART = 1'b0;
      for (int px = 0; px < n; px++) begin
        if (ln == rstLine && (px == rstPix || px == rstPix + 1)) iRST_N = 1'b0;
        if (ln == rstLine && px == rstPix + 2) begin iRST_N = 1'b1; clearCounters(); end
        iLVAL = 1'b1;
        iDATA = DW'(px + 16 * ln);
        if (ln == 0 && px == 0) frameFirstDrive = cyc;
        tick();
      end
      iLVAL = 1'b0;
      if (coinc && ln == lines - 1) begin
        iFVAL = 1'b0;
        tick();
      end else begin
        tick(); tick();
      end
    end
    iFVAL = 1'b0; iLVAL = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with toggling inputs
    iRST_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iFVAL = (i % 2 == 0); iLVAL = (i % 2 != 0); iDATA = DW'(10'h155 ^ i); iSTART = 1'b1;
      tick();
    end
    iRST_N = 1'b1; iFVAL = 1'b0; iLVAL = 1'b0; iDATA = '0; iSTART = 1'b0;
    tick();
    @(negedge iCLK);
    check("reset_outputs", {10'd0, oDVAL, oDATA, oX, oY, oSOF, oEOF, oFRAME_CNT, oERR}, 64'd0);
    repeat (3) tick();

    // Nominal 4x8 frame
    iSTART = 1'b1;
    repeat (3) tick();
    clearCounters();
    sendFrame(4, 8, -1, 0, -1, -1, 1'b0, -1, 0);
    check("nom_dval_count", 64'(dvalCnt), 64'd32);
    check("nom_latency", 64'(firstCyc - frameFirstDrive), 64'd2);
    check("nom_sof_count", 64'(sofCnt), 64'd1);
    check("nom_sof_data", 64'(sofData), 64'd0);
    check("nom_last_x", 64'(lastX), 64'd7);
    check("nom_last_y", 64'(lastY), 64'd3);
    check("nom_last_data", 64'(lastData), 64'h37);
    check("nom_eof_count", 64'(eofCnt), 64'd1);
    check("nom_frame_cnt", 64'(oFRAME_CNT), 64'd1);
    check("nom_err", 64'(oERR), 64'd0);

    // Arm in the middle of a frame
    iSTART = 1'b0;
    repeat (3) tick();
    clearCounters();
    sendFrame(4, 8, -1, 0, 2, -1, 1'b0, -1, 0);
    check("arm_partial_dval", 64'(dvalCnt), 64'd0);
    check("arm_partial_eof", 64'(eofCnt), 64'd0);
    clearCounters();
    sendFrame(4, 8, -1, 0, -1, -1, 1'b0, -1, 0);
    check("arm_first_xy_sof", {firstX, firstY, 7'd0, firstSof}, 64'd1);
    check("arm_dval_count", 64'(dvalCnt), 64'd32);
    check("arm_frame_cnt", 64'(oFRAME_CNT), 64'd2);

    // Overlength line then clean frame
    clearCounters();
    sendFrame(4, 8, 1, 10, -1, -1, 1'b0, -1, 0);
    check("long_dval_count", 64'(dvalCnt), 64'd32);
    check("long_err", 64'(oERR), 64'd1);
    clearCounters();
    sendFrame(4, 8, -1, 0, -1, -1, 1'b0, -1, 0);
    check("long_err_sticky", 64'(oERR), 64'd1);
    check("long_clean_last", 64'(lastData), 64'h37);

    // Stop during capture
    clearCounters();
    sendFrame(4, 8, -1, 0, -1, 1, 1'b0, -1, 0);
    check("stop_dval_count", 64'(dvalCnt), 64'd32);
    check("stop_eof_count", 64'(eofCnt), 64'd1);
    check("stop_frame_cnt", 64'(oFRAME_CNT), 64'd5);
    clearCounters();
    sendFrame(4, 8, -1, 0, -1, -1, 1'b0, -1, 0);
    check("stop_next_dval", 64'(dvalCnt), 64'd0);
    check("stop_next_eof", 64'(eofCnt), 64'd0);

    // Coincident LVAL/FVAL fall
    iSTART = 1'b1;
    repeat (3) tick();
    clearCounters();
    sendFrame(4, 8, -1, 0, -1, -1, 1'b1, -1, 0);
    check("coinc_eof_count", 64'(eofCnt), 64'd1);
    check("coinc_frame_cnt", 64'(oFRAME_CNT), 64'd6);
    check("coinc_dval_count", 64'(dvalCnt), 64'd32);

    // Reset at pixel 5 of line 2, then a full frame
    sendFrame(4, 8, -1, 0, -1, -1, 1'b0, 2, 5);
    check("rst_post_dval", 64'(dvalCnt), 64'd0);
    check("rst_eof_count", 64'(eofCnt), 64'd0);
    check("rst_frame_cnt", 64'(oFRAME_CNT), 64'd0);
    check("rst_err_clear", 64'(oERR), 64'd0);
    clearCounters();
    sendFrame(4, 8, -1, 0, -1, -1, 1'b0, -1, 0);
    check("rst_restart_dval", 64'(dvalCnt), 64'd32);
    check("rst_restart_sof", 64'(sofCnt), 64'd1);
    check("rst_restart_cnt", 64'(oFRAME_CNT), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
